acc_stream_rx: RTL

Receive stage between the SDRAM-read DMA and the accelerator core. It captures the DMA's push-only word stream (`acc_data_valid_i`/`acc_data_i`, no backpressure) into a small FIFO. It re-issues the words on a valid/ready interface with frame delimiting, so the core can stall without losing burst data. Overflow is detected and reported rather than back-pressured.

---
 rtl/acc_stream_rx_pkg.sv | 38 +++
 rtl/acc_stream_rx_if.sv | 40 ++++
 rtl/acc_stream_rx_fifo.sv | 72 +++++++
 rtl/acc_stream_rx.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/acc_stream_rx_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : acc_stream_rx_pkg
//  Description : Shared types, default constants and helpers for the
//                accelerator stream receive stage.
//  Revision    : 1.0 - initial release
// ============================================================================
package acc_stream_rx_pkg;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_DEPTH      = 8;

    // Output register occupancy
    typedef enum logic [0:0] {
        OUT_EMPTY = 1'b0,
        OUT_HOLD  = 1'b1
    } out_state_e;

    // Frame delimiting state
    typedef enum logic [0:0] {
        FRM_IDLE     = 1'b0,
        FRM_IN_FRAME = 1'b1
    } frm_state_e;

    // Ceiling log2, usable in constant expressions
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage
`default_nettype wire

// File: rtl/acc_stream_rx_if.sv
`default_nettype none
// ============================================================================
//  Module      : acc_stream_rx_if
//  Description : DMA push stream in, valid/ready framed stream out.
//                slave  = receive stage view, master = producer/consumer view.
//  Revision    : 1.0 - initial release
// ============================================================================
interface acc_stream_rx_if
    import acc_stream_rx_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) ();

    logic                  acc_data_valid_i;
    logic [DATA_WIDTH-1:0] acc_data_i;
    logic                  m_valid_o;
    logic [DATA_WIDTH-1:0] m_data_o;
    logic                  m_last_o;
    logic                  m_ready_i;

    modport slave (
        input  acc_data_valid_i,
        input  acc_data_i,
        input  m_ready_i,
        output m_valid_o,
        output m_data_o,
        output m_last_o
    );

    modport master (
        output acc_data_valid_i,
        output acc_data_i,
        output m_ready_i,
        input  m_valid_o,
        input  m_data_o,
        input  m_last_o
    );

endinterface
`default_nettype wire

// File: rtl/acc_stream_rx_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : acc_rx_fifo
//  Description : Synchronous FIFO with registered pointers and level.
//                Head word is presented combinationally; a push into a full
//                FIFO is legal when a pop happens in the same cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module acc_rx_fifo
    import acc_stream_rx_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int DEPTH      = DEF_DEPTH
) (
    input  logic                    clk_i,
    input  logic                    rst_n_i,
    input  logic                    clr_i,
    input  logic                    push_i,
    input  logic [DATA_WIDTH-1:0]   push_data_i,
    input  logic                    pop_i,
    output logic [DATA_WIDTH-1:0]   pop_data_o,
    output logic                    full_o,
    output logic                    empty_o,
    output logic [clog2(DEPTH):0]   level_o
);

    localparam int AW = clog2(DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]         wr_ptr_q;
    logic [AW-1:0]         rd_ptr_q;
    logic [AW:0]           level_q;

    // Storage array; no reset needed, contents are qualified by level
    always_ff @(posedge clk_i) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else if (clr_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push_i) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop_i) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({push_i, pop_i})
                2'b10:   level_q <= level_q + (AW+1)'(1);
                2'b01:   level_q <= level_q - (AW+1)'(1);
                default: level_q <= level_q;
            endcase
        end
    end

    assign pop_data_o = mem_q[rd_ptr_q];
    assign full_o     = (level_q == (AW+1)'(DEPTH));
    assign empty_o    = (level_q == '0);
    assign level_o    = level_q;

endmodule
`default_nettype wire

// File: rtl/acc_stream_rx.sv
`default_nettype none
// ============================================================================
//  Module      : acc_stream_rx
//  Description : Captures the DMA push-only word stream into a FIFO and
//                re-issues it on a valid/ready interface with frame
//                delimiting. Dropped beats set a sticky overflow flag.
//                Optional framing logic: define ACC_STREAM_RX_FRAME_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module acc_stream_rx
    import acc_stream_rx_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int DEPTH      = DEF_DEPTH        // power of two, >= 2
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_n_i,
    acc_stream_rx_if.slave        bus,
    input  logic                  clr_i,
    input  logic [7:0]            cfg_frame_len_i,
    output logic [clog2(DEPTH):0] fifo_level_o,
    output logic                  overflow_o,
    output logic [15:0]           frame_cnt_o
);

    logic                  w_fifo_full;
    logic                  w_fifo_empty;
    logic [DATA_WIDTH-1:0] w_fifo_data;
    logic                  w_hs;
    logic                  w_pop;
    logic                  w_push;
    logic                  w_drop;
    logic                  w_last_new;

    out_state_e            out_state_q, out_state_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  last_q, last_d;
    logic                  ovf_q;

    // Handshake, refill and ingress decisions; clr_i suppresses all traffic
    assign w_hs   = (out_state_q == OUT_HOLD) && bus.m_ready_i;
    assign w_pop  = !clr_i && !w_fifo_empty &&
                    ((out_state_q == OUT_EMPTY) || bus.m_ready_i);
    assign w_push = !clr_i && bus.acc_data_valid_i && (!w_fifo_full || w_pop);
    assign w_drop = !clr_i && bus.acc_data_valid_i && !w_push;

    acc_rx_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_fifo (
        .clk_i       (wb_clk_i),
        .rst_n_i     (wb_rst_n_i),
        .clr_i       (clr_i),
        .push_i      (w_push),
        .push_data_i (bus.acc_data_i),
        .pop_i       (w_pop),
        .pop_data_o  (w_fifo_data),
        .full_o      (w_fifo_full),
        .empty_o     (w_fifo_empty),
        .level_o     (fifo_level_o)
    );

    // Output register: load on pop, drain on handshake, hold while stalled
    always_comb begin
        out_state_d = out_state_q;
        data_d      = data_q;
        last_d      = last_q;
        if (clr_i) begin
            out_state_d = OUT_EMPTY;
            data_d      = '0;
            last_d      = 1'b0;
        end else if (w_pop) begin
            out_state_d = OUT_HOLD;
            data_d      = w_fifo_data;
            last_d      = w_last_new;
        end else if (w_hs) begin
            out_state_d = OUT_EMPTY;
            last_d      = 1'b0;
        end
    end

    // Output stage and sticky overflow state
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            out_state_q <= OUT_EMPTY;
            data_q      <= '0;
            last_q      <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            out_state_q <= out_state_d;
            data_q      <= data_d;
            last_q      <= last_d;
            ovf_q       <= clr_i ? 1'b0 : (ovf_q | w_drop);
        end
    end

`ifdef ACC_STREAM_RX_FRAME_EN
    frm_state_e frm_state_q, frm_state_d;
    logic [7:0] bcnt_q, bcnt_d;
    logic [7:0] flen_q, flen_d;
    logic [15:0] fcnt_q, fcnt_d;
    logic [7:0] w_len_sel;
    logic [8:0] w_len_eff;
    logic [8:0] w_next_beat;

    // Frame tracking advances on each handshake; last beat closes the frame
    always_comb begin
        frm_state_d = frm_state_q;
        bcnt_d      = bcnt_q;
        flen_d      = flen_q;
        fcnt_d      = fcnt_q;
        if (clr_i) begin
            frm_state_d = FRM_IDLE;
            bcnt_d      = '0;
            fcnt_d      = '0;
        end else if (w_hs) begin
            if (frm_state_q == FRM_IDLE) begin
                flen_d = cfg_frame_len_i;
            end
            if (last_q) begin
                frm_state_d = FRM_IDLE;
                bcnt_d      = '0;
                fcnt_d      = fcnt_q + 16'd1;
            end else begin
                frm_state_d = FRM_IN_FRAME;
                bcnt_d      = bcnt_q + 8'd1;
            end
        end
    end

    // A word loading now is beat bcnt_d+1; a fresh frame still follows cfg
    assign w_len_sel   = (frm_state_d == FRM_IDLE) ? cfg_frame_len_i : flen_d;
    assign w_len_eff   = (w_len_sel == 8'd0) ? 9'd256 : {1'b0, w_len_sel};
    assign w_next_beat = {1'b0, bcnt_d} + 9'd1;
    assign w_last_new  = (w_next_beat == w_len_eff);

    // Framing registers
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            frm_state_q <= FRM_IDLE;
            bcnt_q      <= '0;
            flen_q      <= '0;
            fcnt_q      <= '0;
        end else begin
            frm_state_q <= frm_state_d;
            bcnt_q      <= bcnt_d;
            flen_q      <= flen_d;
            fcnt_q      <= fcnt_d;
        end
    end

    assign frame_cnt_o = fcnt_q;
`else
    logic w_unused_cfg;

    assign w_unused_cfg = ^cfg_frame_len_i;
    assign w_last_new   = 1'b0;
    assign frame_cnt_o  = '0;
`endif

    assign bus.m_valid_o = (out_state_q == OUT_HOLD);
    assign bus.m_data_o  = data_q;
    assign bus.m_last_o  = last_q;
    assign overflow_o    = ovf_q;

endmodule
`default_nettype wire
